cpu6_alu_arb: RTL and testbench

Two-port arbiter and sequencer that shares one `cpu6_alu` instance between two requesters, for example the execute stage and the branch/address unit. Each port uses a valid/ready request and a valid/ready response. The block grants one request at a time, registers the operands, and evaluates them in the ALU. It then holds the registered result on the granted port's response channel until that port accepts it. Round-robin or fixed priority is selectable.

---
 rtl/cpu6_alu_arb_pkg.sv | 42 ++++
 rtl/cpu6_alu.sv | 32 +++
 rtl/cpu6_alu_arb.sv | 136 +++++++++++++
 tb/tb_cpu6_alu_arb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu6_alu_arb_pkg.sv
// Shared widths, ALU operation codes and arbiter state encodings
// for the cpu6 ALU arbiter slice.
package cpu6_alu_arb_pkg;

    localparam int CPU6_XLEN            = 32;
    localparam int CPU6_ALUCONTROL_SIZE = 3;

    localparam logic [CPU6_ALUCONTROL_SIZE-1:0] CPU6_ALUCONTROL_AND = 3'b000;
    localparam logic [CPU6_ALUCONTROL_SIZE-1:0] CPU6_ALUCONTROL_OR  = 3'b001;
    localparam logic [CPU6_ALUCONTROL_SIZE-1:0] CPU6_ALUCONTROL_ADD = 3'b010;
    localparam logic [CPU6_ALUCONTROL_SIZE-1:0] CPU6_ALUCONTROL_SUB = 3'b110;

    localparam logic [1:0] CPU6_ALUARB_IDLE = 2'b00;
    localparam logic [1:0] CPU6_ALUARB_EXEC = 2'b01;
    localparam logic [1:0] CPU6_ALUARB_RESP = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = CPU6_ALUARB_IDLE,
        ST_EXEC = CPU6_ALUARB_EXEC,
        ST_RESP = CPU6_ALUARB_RESP
    } arb_state_e;

    typedef struct packed {
        logic [CPU6_XLEN-1:0]            a;
        logic [CPU6_XLEN-1:0]            b;
        logic [CPU6_ALUCONTROL_SIZE-1:0] control;
    } alu_req_t;

    typedef struct packed {
        logic [CPU6_XLEN-1:0] y;
        logic                 zero;
        logic                 err;
    } alu_rsp_t;

    function automatic logic alu_ctl_legal(
        input logic [CPU6_ALUCONTROL_SIZE-1:0] c
    );
        return (c == CPU6_ALUCONTROL_ADD) || (c == CPU6_ALUCONTROL_SUB) ||
               (c == CPU6_ALUCONTROL_AND) || (c == CPU6_ALUCONTROL_OR);
    endfunction

endpackage

// File: rtl/cpu6_alu.sv
// Combinational ADD/SUB/AND/OR unit.
// Unsupported codes give y=0 and zero=0 and raise err.
module cpu6_alu
    import cpu6_alu_arb_pkg::*;
(
    input  logic [CPU6_XLEN-1:0]            a,
    input  logic [CPU6_XLEN-1:0]            b,
    input  logic [CPU6_ALUCONTROL_SIZE-1:0] control,
    output logic [CPU6_XLEN-1:0]            y,
    output logic                            zero,
    output logic                            err
);

    logic legal;

    assign legal = alu_ctl_legal(control);

    always_comb begin
        y = '0;
        unique case (control)
            CPU6_ALUCONTROL_ADD: y = a + b;
            CPU6_ALUCONTROL_SUB: y = a - b;
            CPU6_ALUCONTROL_AND: y = a & b;
            CPU6_ALUCONTROL_OR:  y = a | b;
            default:             y = '0;
        endcase
    end

    assign zero = legal & (y == '0);
    assign err  = ~legal;

endmodule

// File: rtl/cpu6_alu_arb.sv
// Two-port valid/ready arbiter sharing one cpu6_alu.
// One operation in flight: IDLE grant -> EXEC evaluate -> RESP hold.
module cpu6_alu_arb
    import cpu6_alu_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            req0_valid,
    output logic                            req0_ready,
    input  logic [CPU6_XLEN-1:0]            req0_a,
    input  logic [CPU6_XLEN-1:0]            req0_b,
    input  logic [CPU6_ALUCONTROL_SIZE-1:0] req0_control,
    output logic                            rsp0_valid,
    input  logic                            rsp0_ready,
    output logic [CPU6_XLEN-1:0]            rsp0_y,
    output logic                            rsp0_zero,
    output logic                            rsp0_err,
    input  logic                            req1_valid,
    output logic                            req1_ready,
    input  logic [CPU6_XLEN-1:0]            req1_a,
    input  logic [CPU6_XLEN-1:0]            req1_b,
    input  logic [CPU6_ALUCONTROL_SIZE-1:0] req1_control,
    output logic                            rsp1_valid,
    input  logic                            rsp1_ready,
    output logic [CPU6_XLEN-1:0]            rsp1_y,
    output logic                            rsp1_zero,
    output logic                            rsp1_err,
    output logic                            busy
);

    arb_state_e state_q, state_d;
    logic       ptr_q;
    logic       owner_q;
    alu_req_t   op_q;
    alu_rsp_t   res_q;

    logic                 idle, both_valid;
    logic                 grant0, grant1;
    logic                 req_hs, rsp_hs;
    logic [CPU6_XLEN-1:0] alu_y;
    logic                 alu_zero, alu_err;

    assign idle       = (state_q == ST_IDLE);
    assign both_valid = req0_valid & req1_valid;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        unique case (1'b1)
            both_valid: begin
                if (!RR_EN || !ptr_q) grant0 = 1'b1;
                else                  grant1 = 1'b1;
            end
            req0_valid & ~req1_valid: grant0 = 1'b1;
            ~req0_valid & req1_valid: grant1 = 1'b1;
            default: ;
        endcase
    end

    // resetn gates ready so nothing is accepted while reset is held
    assign req0_ready = idle & grant0 & resetn;
    assign req1_ready = idle & grant1 & resetn;
    assign req_hs     = req0_ready | req1_ready;

    assign rsp_hs = (state_q == ST_RESP) &
                    (owner_q ? rsp1_ready : rsp0_ready);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_hs) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_hs) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // pointer only moves on contested grants
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            op_q    <= '0;
        end else if (req_hs) begin
            owner_q <= grant1;
            if (RR_EN && both_valid) ptr_q <= grant0;
            if (grant1) begin
                op_q <= alu_req_t'{a: req1_a, b: req1_b,
                                   control: req1_control};
            end else begin
                op_q <= alu_req_t'{a: req0_a, b: req0_b,
                                   control: req0_control};
            end
        end
    end

    cpu6_alu u_alu (
        .a       (op_q.a),
        .b       (op_q.b),
        .control (op_q.control),
        .y       (alu_y),
        .zero    (alu_zero),
        .err     (alu_err)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_q <= '0;
        end else if (state_q == ST_EXEC) begin
            res_q <= alu_rsp_t'{y: alu_y, zero: alu_zero, err: alu_err};
        end
    end

    assign rsp0_valid = (state_q == ST_RESP) & ~owner_q;
    assign rsp1_valid = (state_q == ST_RESP) & owner_q;

    assign rsp0_y    = res_q.y;
    assign rsp0_zero = res_q.zero;
    assign rsp0_err  = res_q.err;
    assign rsp1_y    = res_q.y;
    assign rsp1_zero = res_q.zero;
    assign rsp1_err  = res_q.err;

    assign busy = ~idle;

endmodule

// File: tb/tb_cpu6_alu_arb.sv
// Scoreboard bench for cpu6_alu_arb: drivers push expected results,
// a monitor pops and compares on each response handshake.
module tb_cpu6_alu_arb;
    import cpu6_alu_arb_pkg::*;

    typedef struct {
        int          p;
        logic [31:0] y;
        logic        z;
        logic        e;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_control = '0, req1_control = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] rsp0_y, rsp1_y;
    logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
    logic        busy;

    logic        f_v0 = 1'b0, f_v1 = 1'b0;
    logic        f_r0, f_r1, f_sv0, f_sv1, f_z0, f_z1, f_e0, f_e1, f_busy;
    logic [31:0] f_y0, f_y1;
    logic [31:0] f_zero_w = '0;
    logic [2:0]  f_ctl = 3'b010;

    exp_t sb[$];
    int   grants[$];
    int   hs_cyc[2];
    int   last_rsp_cyc[2];
    bit   pv[2];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    cpu6_alu_arb #(.RR_EN(1'b1)) u_dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_control(req0_control),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_y(rsp0_y), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_control(req1_control),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_y(rsp1_y), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .busy(busy)
    );

    cpu6_alu_arb #(.RR_EN(1'b0)) u_fp (
        .clk(clk), .resetn(resetn),
        .req0_valid(f_v0), .req0_ready(f_r0),
        .req0_a(f_zero_w), .req0_b(f_zero_w), .req0_control(f_ctl),
        .rsp0_valid(f_sv0), .rsp0_ready(1'b1),
        .rsp0_y(f_y0), .rsp0_zero(f_z0), .rsp0_err(f_e0),
        .req1_valid(f_v1), .req1_ready(f_r1),
        .req1_a(f_zero_w), .req1_b(f_zero_w), .req1_control(f_ctl),
        .rsp1_valid(f_sv1), .rsp1_ready(1'b1),
        .rsp1_y(f_y1), .rsp1_zero(f_z1), .rsp1_err(f_e1),
        .busy(f_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction

    task automatic issue(input int p, input logic [31:0] a, b,
                         input logic [2:0] c, input logic [31:0] ey,
                         input logic ez, ee, input bit push);
        int n = 0;
        @(negedge clk);
        if (p == 0) begin
            req0_a = a; req0_b = b; req0_control = c; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_control = c; req1_valid = 1'b1;
        end
        #1;
        while (!rdy(p) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!rdy(p)) begin
            n_cmp++;
            n_err++;
            $display("FAIL req%0d_timeout: got no ready want ready", p);
        end else begin
            if (push) sb.push_back('{p, ey, ez, ee, cyc + 2});
            grants.push_back(p);
            hs_cyc[p] = cyc;
            @(posedge clk);
            #1;
        end
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic mon_port(input int p);
        logic        v, r, z, e;
        logic [31:0] y;
        exp_t        x;
        v = (p == 0) ? rsp0_valid : rsp1_valid;
        r = (p == 0) ? rsp0_ready : rsp1_ready;
        y = (p == 0) ? rsp0_y : rsp1_y;
        z = (p == 0) ? rsp0_zero : rsp1_zero;
        e = (p == 0) ? rsp0_err : rsp1_err;
        if (v) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rsp%0d: got valid want idle", p);
            end else begin
                x = sb[0];
                if (!pv[p]) begin
                    chk("rsp_port", 32'(p), 32'(x.p));
                    chk("rsp_latency", 32'(cyc), 32'(x.cyc));
                end
                chk("rsp_y", y, x.y);
                chk("rsp_zero", 32'(z), 32'(x.z));
                chk("rsp_err", 32'(e), 32'(x.e));
                if (r) begin
                    void'(sb.pop_front());
                    last_rsp_cyc[p] = cyc;
                end
            end
        end
        pv[p] = v;
    endtask

    always @(negedge clk) begin
        #2;
        if (!resetn) begin
            pv[0] = 1'b0;
            pv[1] = 1'b0;
        end else begin
            if (rsp0_valid || rsp1_valid)
                chk("rsp_onehot", 32'(rsp0_valid & rsp1_valid), 32'd0);
            for (int p = 0; p < 2; p++) mon_port(p);
        end
    end

    initial begin
        int c0, c1, n;

        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #12;
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("rst_rsp_y", rsp0_y, 32'd0);
        chk("rst_rsp_zero", 32'(rsp1_zero), 32'd0);
        chk("rst_rsp_err", 32'(rsp0_err), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        issue(0, 32'd5, 32'd3, CPU6_ALUCONTROL_ADD, 32'd8, 1'b0, 1'b0, 1'b1);
        issue(1, 32'd7, 32'd7, CPU6_ALUCONTROL_SUB, 32'd0, 1'b1, 1'b0, 1'b1);
        issue(1, 32'd0, 32'd1, CPU6_ALUCONTROL_SUB, 32'hFFFF_FFFF,
              1'b0, 1'b0, 1'b1);

        grants.delete();
        fork
            begin
                issue(0, 32'hF0F0, 32'hFF00, CPU6_ALUCONTROL_AND,
                      32'hF000, 1'b0, 1'b0, 1'b1);
                issue(0, 32'hA0, 32'h05, CPU6_ALUCONTROL_OR,
                      32'hA5, 1'b0, 1'b0, 1'b1);
            end
            issue(1, 32'd3, 32'd5, CPU6_ALUCONTROL_SUB, 32'hFFFF_FFFE,
                  1'b0, 1'b0, 1'b1);
        join
        chk("rr_grant_count", 32'(grants.size()), 32'd3);
        if (grants.size() == 3) begin
            chk("rr_grant0", 32'(grants[0]), 32'd0);
            chk("rr_grant1", 32'(grants[1]), 32'd1);
            chk("rr_grant2", 32'(grants[2]), 32'd0);
        end

        rsp0_ready = 1'b0;
        fork
            issue(0, 32'd1, 32'd2, CPU6_ALUCONTROL_ADD, 32'd3,
                  1'b0, 1'b0, 1'b1);
            begin
                @(negedge clk);
                issue(1, 32'd10, 32'd4, CPU6_ALUCONTROL_SUB, 32'd6,
                      1'b0, 1'b0, 1'b1);
            end
            begin
                n = 0;
                @(negedge clk);
                #3;
                while (!rsp0_valid && n < 20) begin
                    @(negedge clk);
                    #3;
                    n++;
                end
                chk("bp_rsp0_seen", 32'(rsp0_valid), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    chk("bp_req1_ready", 32'(req1_ready), 32'd0);
                    chk("bp_busy", 32'(busy), 32'd1);
                    @(negedge clk);
                    #3;
                end
                @(negedge clk);
                rsp0_ready = 1'b1;
            end
        join
        chk("bp_req1_after_rsp0", 32'(hs_cyc[1]),
            32'(last_rsp_cyc[0] + 1));

        issue(0, 32'hF, 32'h1, 3'b111, 32'd0, 1'b0, 1'b1, 1'b1);

        issue(0, 32'd1, 32'd1, CPU6_ALUCONTROL_ADD, 32'd2, 1'b0, 1'b0, 1'b0);
        chk("exec_busy", 32'(busy), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("mid_rst_rsp_err", 32'(rsp0_err), 32'd0);
        chk("mid_rst_rsp_y", rsp1_y, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        issue(1, 32'hFFFF_FFFF, 32'd1, CPU6_ALUCONTROL_ADD, 32'd0,
              1'b1, 1'b0, 1'b1);
        issue(0, 32'h7FFF_FFFF, 32'd1, CPU6_ALUCONTROL_ADD, 32'h8000_0000,
              1'b0, 1'b0, 1'b1);

        c0 = 0;
        c1 = 0;
        @(negedge clk);
        f_v0 = 1'b1;
        f_v1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #3;
            c0 += int'(f_r0);
            c1 += int'(f_r1);
            @(negedge clk);
        end
        f_v0 = 1'b0;
        f_v1 = 1'b0;
        chk("fp_port0_grants", 32'(c0), 32'd4);
        chk("fp_port1_grants", 32'(c1), 32'd0);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
